// File: rtl/sap1_datapath.sv
// SAP-1 datapath: PC, MAR, IR, A, B, OUT registers, 16x8 program RAM,
// an add/subtract ALU and a single 8-bit bus with fixed driver priority.
// The controller supplies a 12-bit control word each cycle. A programming
// port loads the RAM while the datapath ignores the control word.
module sap1_datapath (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [11:0] i_cw,
  input  logic        i_hlt,
  input  logic        i_prog_en,
  input  logic        i_prog_we,
  input  logic [3:0]  i_prog_addr,
  input  logic [7:0]  i_prog_data,
  output logic [3:0]  o_opcode,
  output logic [7:0]  o_out_data,
  output logic [7:0]  o_bus,
  output logic [3:0]  o_pc,
  output logic        o_bus_err
);

  logic [3:0] r_pc;
  logic [3:0] r_mar;
  logic [7:0] r_ir;
  logic [7:0] r_a;
  logic [7:0] r_b;
  logic [7:0] r_out;
  logic       r_busErr;
  logic [7:0] r_ram [16];

  logic w_ce, w_co, w_mi, w_ro, w_ii, w_io, w_ai, w_ao, w_su, w_eo, w_bi, w_oi;
  logic       w_cwActive;
  logic [2:0] w_drvCount;
  logic [7:0] w_alu;
  logic [7:0] w_bus;

  assign w_ce = i_cw[11];
  assign w_co = i_cw[10];
  assign w_mi = i_cw[9];
  assign w_ro = i_cw[8];
  assign w_ii = i_cw[7];
  assign w_io = i_cw[6];
  assign w_ai = i_cw[5];
  assign w_ao = i_cw[4];
  assign w_su = i_cw[3];
  assign w_eo = i_cw[2];
  assign w_bi = i_cw[1];
  assign w_oi = i_cw[0];

  // The control word only acts on registers when neither halted nor programming.
  assign w_cwActive = !i_hlt && !i_prog_en;

  assign w_drvCount = {2'b00, w_co} + {2'b00, w_ro} + {2'b00, w_io}
                    + {2'b00, w_ao} + {2'b00, w_eo};

  // ALU wraps modulo 256; subtraction is plain two's complement.
  assign w_alu = w_su ? (r_a - r_b) : (r_a + r_b);

  // Bus mux with fixed priority so a conflicting control word still yields a defined value.
  always_comb begin
    w_bus = 8'h00;
    if (w_co)      w_bus = {4'h0, r_pc};
    else if (w_ro) w_bus = r_ram[r_mar];
    else if (w_io) w_bus = {4'h0, r_ir[3:0]};
    else if (w_ao) w_bus = r_a;
    else if (w_eo) w_bus = w_alu;
  end

  // Program RAM: written only through the programming port and never reset.
  always_ff @(posedge i_clk) begin
    if (i_prog_en && i_prog_we) begin
      r_ram[i_prog_addr] <= i_prog_data;
    end
  end

  // Datapath registers load from the bus; all sample pre-edge values so driver and loader can share a cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pc  <= 4'h0;
      r_mar <= 4'h0;
      r_ir  <= 8'h00;
      r_a   <= 8'h00;
      r_b   <= 8'h00;
      r_out <= 8'h00;
    end else if (w_cwActive) begin
      if (w_ce) r_pc  <= r_pc + 4'h1;
      if (w_mi) r_mar <= w_bus[3:0];
      if (w_ii) r_ir  <= w_bus;
      if (w_ai) r_a   <= w_bus;
      if (w_bi) r_b   <= w_bus;
      if (w_oi) r_out <= w_bus;
    end
  end

  // Sticky contention flag: once two drivers fight for the bus it stays set until reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_busErr <= 1'b0;
    end else if (w_cwActive && (w_drvCount > 3'd1)) begin
      r_busErr <= 1'b1;
    end
  end

  assign o_opcode   = r_ir[7:4];
  assign o_out_data = r_out;
  assign o_bus      = w_bus;
  assign o_pc       = r_pc;
  assign o_bus_err  = r_busErr;

endmodule

// File: doc/sap1_datapath.md
SAP1_DATAPATH -- requirements
Module: sap1_datapath

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Port: CLK  input  1  system clock; all datapath registers update on posedge.
REQ-003 Port: RST_N  input  1  asynchronous active-low reset.
REQ-004 Port: CW  input  12  control word from controller; bit 11..0 = CE, CO, MI, RO, II, IO, AI, AO, SU, EO, BI, OI.
REQ-005 Port: HLT  input  1  halt; 1 inhibits all register updates driven by CW.
REQ-006 Port: PROG_EN  input  1  programming mode; 1 ignores CW entirely.
REQ-007 Port: PROG_WE  input  1  RAM write strobe, honoured only when PROG_EN=1.
REQ-008 Port: PROG_ADDR  input  4  RAM programming address.
REQ-009 Port: PROG_DATA  input  8  RAM programming data.
REQ-010 Port: OPCODE  output  4  IR[7:4], to controller.
REQ-011 Port: OUT_DATA  output  8  output register contents.
REQ-012 Port: BUS  output  8  current bus value, observability.
REQ-013 Port: PC  output  4  program counter value.
REQ-014 Port: BUS_ERR  output  1  sticky flag: more than one bus driver asserted.

Function
REQ-015 SHALL contain registers PC[3:0], MAR[3:0], IR[7:0], A[7:0], B[7:0], OUT[7:0], and a 16x8 RAM.
REQ-016 Bus combinational, driver priority CO > RO > IO > AO > EO; no driver -> BUS = 8'h00.
REQ-017 Driver values: CO -> {4'h0, PC}; RO -> RAM[MAR]; IO -> {4'h0, IR[3:0]}; AO -> A; EO -> ALU.
REQ-018 ALU combinational: SU=0 -> A+B, SU=1 -> A-B (two's complement), result truncated to 8 bits, wrap-around, no carry output.
REQ-019 On posedge when HLT=0 and PROG_EN=0: MI -> MAR<=BUS[3:0]; II -> IR<=BUS; AI -> A<=BUS; BI -> B<=BUS; OI -> OUT<=BUS; CE -> PC<=PC+1.
REQ-020 PC SHALL wrap 4'hF -> 4'h0 on CE.
REQ-021 Simultaneous driver and loader in same cycle use pre-edge values (e.g. CO+CE: bus shows old PC, PC increments; EO+AI: A<=old A op old B).
REQ-022 Multiple loaders in same cycle all load the same BUS value.
REQ-023 When two or more of CO, RO, IO, AO, EO are 1 while HLT=0 and PROG_EN=0, BUS_ERR SHALL set on the next posedge and remain 1 until reset.
REQ-024 HLT=1 SHALL freeze PC, MAR, IR, A, B, OUT; BUS continues to reflect CW combinationally.
REQ-025 PROG_EN=1 and PROG_WE=1 -> RAM[PROG_ADDR]<=PROG_DATA on posedge, regardless of HLT.
REQ-026 PROG_EN=1 SHALL block all CW-driven loads and BUS_ERR updates; BUS still reflects CW.
REQ-027 RAM SHALL have no CW write path; RAM contents change only through the programming port.
REQ-028 RAM read (RO) SHALL be combinational from MAR, so a PROG write is visible on BUS the cycle after the write edge.
REQ-029 OPCODE, OUT_DATA, PC SHALL be direct register outputs, valid one posedge after the load.

Reset
REQ-030 RST_N=0 SHALL immediately clear PC, MAR, IR, A, B, OUT to 0 and BUS_ERR to 0, independent of CLK.
REQ-031 RAM contents SHALL NOT be affected by reset.
REQ-032 Reset asserted mid-instruction SHALL abandon the in-flight operation; the first edge after RST_N rises SHALL act on the then-current CW only.

Verification
REQ-033 Program RAM[0]=8'h1E, RAM[E]=8'h07, then fetch (CO+MI; RO+II+CE) -> OPCODE=4'h1, PC=1, MAR=0.
REQ-034 A=8'hF0, B=8'h20, CW=EO+AI -> A=8'h10 (wrap); then SU=1, EO+AI with B=8'h20 -> A=8'hF0.
REQ-035 PC=4'hF, CW=CE -> PC=4'h0; with HLT=1, CE held 3 cycles -> PC unchanged.
REQ-036 CW=CO+AO asserted one cycle -> BUS={4'h0,PC}, BUS_ERR=1 after edge and stays 1 after CW clears; RST_N pulse -> BUS_ERR=0.
REQ-037 A=8'h2A, CW=AO+OI -> OUT_DATA=8'h2A; RST_N=0 between edges -> OUT_DATA=8'h00 before next posedge, RAM[E] still 8'h07.
REQ-038 PROG_EN=1 with CW=AI+BI+OI and BUS driven -> A, B, OUT unchanged; PROG_WE writes RAM[3]=8'h55, then PROG_EN=0, MAR=3, RO -> BUS=8'h55.
